// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial 8-bit subtractor (f = a - b - bin), LSB first,
//            start/done handshake, 8080-style flag outputs.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor (
    input  logic       p_reset,
    input  logic       m_clock,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] f,
    output logic       cy,
    output logic       z,
    output logic       s,
    output logic       p,
    output logic       ac
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_br;
    logic [7:0] r_sr;
    logic       r_ac_hold;

    logic       w_ai;
    logic       w_bi;
    logic       w_d;
    logic       w_br_next;
    logic [7:0] w_sr_next;

    assign w_ai      = r_a[r_cnt];
    assign w_bi      = r_b[r_cnt];
    assign w_d       = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    // Result bits enter from the MSB side so bit 0 lands in f[0] after 8 shifts.
    assign w_sr_next = {w_d, r_sr[7:1]};

    assign busy = (r_state == c_RUN);

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 3'd0;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_br      <= 1'b0;
            r_sr      <= 8'h00;
            r_ac_hold <= 1'b0;
            done      <= 1'b0;
            f         <= 8'h00;
            cy        <= 1'b0;
            z         <= 1'b1;
            s         <= 1'b0;
            p         <= 1'b1;
            ac        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= 3'd0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_sr <= w_sr_next;
                    r_br <= w_br_next;
                    if (r_cnt == 3'd3) begin
                        r_ac_hold <= w_br_next;
                    end
                    if (r_cnt == 3'd7) begin
                        f       <= w_sr_next;
                        cy      <= w_br_next;
                        z       <= (w_sr_next == 8'h00);
                        s       <= w_sr_next[7];
                        p       <= ~(^w_sr_next);
                        ac      <= r_ac_hold;
                        done    <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    logic       p_reset;
    logic       m_clock;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] f;
    logic       cy;
    logic       z;
    logic       s;
    logic       p;
    logic       ac;

    int n_checks = 0;
    int n_fails  = 0;

    serial_subtractor u_dut (
        .p_reset (p_reset),
        .m_clock (m_clock),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .f       (f),
        .cy      (cy),
        .z       (z),
        .s       (s),
        .p       (p),
        .ac      (ac)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    // Present operands with start for one edge (E0); returns just after E0.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    // Wait (bounded) for done; n0 = edges already elapsed since E0.
    task automatic wait_done(input string tag, input int n0, input logic [7:0] ef,
                             input logic ecy, input logic ez, input logic es,
                             input logic ep, input logic eac);
        int n;
        n = n0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_f"}, f, ef);
        check({tag, "_cy"}, cy, ecy);
        check({tag, "_z"}, z, ez);
        check({tag, "_s"}, s, es);
        check({tag, "_p"}, p, ep);
        check({tag, "_ac"}, ac, eac);
    endtask

    task automatic pulse_end(input string tag);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        p_reset = 1'b1;
        start   = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        bin     = 1'b0;
        repeat (2) @(posedge m_clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_f", f, 8'h00);
        check("rst_cy", cy, 0);
        check("rst_z", z, 1);
        check("rst_s", s, 0);
        check("rst_p", p, 1);
        check("rst_ac", ac, 0);
        p_reset = 1'b0;
        tick();

        // 0x50 - 0x20 = 0x30
        issue(8'h50, 8'h20, 1'b0);
        a = 8'hAA; b = 8'h55; bin = 1'b1;   // operand changes after acceptance
        wait_done("t1", 0, 8'h30, 0, 0, 0, 1, 0);
        pulse_end("t1");

        // 0x20 - 0x50 = 0xD0 with borrow
        issue(8'h20, 8'h50, 1'b0);
        wait_done("t2", 0, 8'hD0, 1, 0, 1, 0, 0);
        pulse_end("t2");

        // 0x10 - 0x01 = 0x0F, nibble borrow; a second start at E3 is ignored
        issue(8'h10, 8'h01, 1'b0);
        tick();
        tick();
        a = 8'h33; b = 8'h44; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_flags_hold_f", f, 8'hD0);
        check("t3_flags_hold_cy", cy, 1);
        wait_done("t3", 3, 8'h0F, 0, 0, 0, 1, 1);
        pulse_end("t3");
        tick();
        check("t3_no_second_op", busy, 0);

        // 0x00 - 0x00 - 1 = 0xFF, then back-to-back 0x42 - 0x42
        issue(8'h00, 8'h00, 1'b1);
        wait_done("t4", 0, 8'hFF, 1, 0, 1, 1, 1);
        a = 8'h42; b = 8'h42; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4b_done_pulse", done, 0);
        check("t4b_busy", busy, 1);
        check("t4b_hold_f", f, 8'hFF);
        wait_done("t4b", 0, 8'h00, 0, 1, 0, 1, 0);
        pulse_end("t4b");

        // 0x05 - 0x03 = 0x02
        issue(8'h05, 8'h03, 1'b0);
        wait_done("t5", 0, 8'h02, 0, 0, 0, 0, 0);
        pulse_end("t5");

        // Reset in the middle of an operation
        issue(8'h50, 8'h20, 1'b0);
        tick();
        tick();
        tick();
        p_reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_f", f, 8'h00);
        check("mid_rst_z", z, 1);
        check("mid_rst_p", p, 1);
        tick();
        p_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_rst_no_done", done, 0);
        end

        // Fresh operation after reset: 0x7F - 0x01 - 1 = 0x7D
        issue(8'h7F, 8'h01, 1'b1);
        wait_done("t6", 0, 8'h7D, 0, 0, 0, 1, 0);
        pulse_end("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial 8-bit subtractor with borrow-in and 8080-style flag generation. It computes f = a − b − bin one bit per cycle, LSB first, behind a start/done handshake. It is the subtract-direction counterpart of the registered operand/adder datapath in the 8080 bench, and it trades area for latency. The result and flags stay registered until the next operation completes.

## Interface
- No parameters; the width is fixed at 8 bits.
- p_reset  in  1  asynchronous, active-high reset
- m_clock  in  1  clock; all state updates on the rising edge
- start  in  1  request; sampled only while busy=0
- a  in  8  minuend; latched on an accepted start
- b  in  8  subtrahend; latched on an accepted start
- bin  in  1  borrow-in; latched on an accepted start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when f and the flags are updated
- f  out  8  registered difference
- cy  out  1  borrow out of bit 7
- z  out  1  1 when f == 0x00
- s  out  1  f[7]
- p  out  1  even parity of f (1 when f has an even number of ones)
- ac  out  1  borrow out of bit 3

## Operation
- The state machine has two states, IDLE and RUN. done is a registered pulse, not a state.
- IDLE, start=1: latch a, b and bin into internal registers. Set the bit counter to 0, initialise the borrow flop to bin, and go to RUN.
- IDLE, start=0: no change.
- RUN, each cycle at bit index i = counter:
  - Result bit: d = a_i ^ b_i ^ br.
  - Next borrow: br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d is shifted into an internal result shift register from the MSB side, shifting right.
  - At i = 3, br' is captured into the ac holding flop.
  - Otherwise the counter increments.
- RUN at i = 7:
  - Write the completed shift register into f.
  - Set cy = br'.
  - Derive z, s and p from the new f.
  - Copy the ac holding flop to ac.
  - Assert done for the next cycle and return to IDLE.
- start while busy=1 is ignored. There is no queueing, and the operands in flight are not modified.
- Changes on a, b or bin after acceptance have no effect on the operation in progress.
- f and all flags change only on the completing edge and hold otherwise, including while a new operation runs.
- Arithmetic is modulo 256 with borrow semantics: cy=1 exactly when a < b + bin as unsigned integers.

## Timing
- Edge E0 samples start=1 in IDLE. busy=1 from after E0 until E8.
- Bits 0..7 are processed on edges E1..E8.
- On E8, f and the flags update, done goes to 1 and busy goes to 0.
- done is high for exactly the one cycle after E8.
- start is accepted on E9 if asserted in the done cycle, giving back-to-back throughput of one result every 9 cycles.
- Latency from the accepting edge to valid f is 8 edges.
- Reset values: busy=0, done=0, f=0x00, cy=0, z=1, s=0, p=1, ac=0. The FSM goes to IDLE and the counter, borrow and shift register are cleared.
- Reset asserted mid-operation aborts the operation immediately (asynchronously). No done is produced and the outputs take their reset values.
- start held high continuously: a new operation begins on every IDLE sample, i.e. E0, E9, E18, and so on.

## Test plan
- Reset, then a=0x50, b=0x20, bin=0 with a one-cycle start -> after 8 edges: f=0x30, cy=0, z=0, s=0, p=1, ac=0; done is a single-cycle pulse.
- a=0x20, b=0x50, bin=0 -> f=0xD0, cy=1, s=1, p=0, z=0, ac=0.
- a=0x10, b=0x01, bin=0 -> f=0x0F, cy=0, ac=1, p=1.
  - Pulse start again at E3: it must be ignored, and the result is unchanged.
- a=0x00, b=0x00, bin=1 -> f=0xFF, cy=1, ac=1, s=1, p=1, z=0.
  - Then a=0x42, b=0x42, bin=0 with start asserted in the done cycle -> f=0x00, z=1, p=1, cy=0, completing 9 edges after the first done.
- Start a=0x50, b=0x20, then assert p_reset at E4 -> busy=0, f=0x00, z=1, and no done pulse.
  - A fresh operation afterwards completes correctly.
